// File: rtl/hd_program_loader.sv
// hd_program_loader: copies a block of HD words into instruction memory while holding the CPU.
module hd_program_loader #(
  parameter int HD_AW  = 12,
  parameter int IM_AW  = 10,
  parameter int DW     = 32,
  parameter int HD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [HD_AW-1:0]  hd_base,
  input  logic [IM_AW-1:0]  im_base,
  input  logic [IM_AW:0]    length,
  output logic [HD_AW-1:0]  HDaddress,
  input  logic [DW-1:0]     HDIndata,
  output logic              im_we,
  output logic [IM_AW-1:0]  im_addr,
  output logic [DW-1:0]     im_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic              aborted
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_FINISH} state_t;
  state_t             r_state;
  logic [HD_AW-1:0]   r_hd_base;
  logic [IM_AW-1:0]   r_im_base;
  logic [IM_AW:0]     r_len;
  logic [IM_AW:0]     r_i;
  logic [1:0]         r_cnt;
  logic [HD_AW-1:0]   r_hd_addr;
  logic               r_we;
  logic [IM_AW-1:0]   r_im_addr;
  logic [DW-1:0]      r_im_data;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               r_aborted;
  logic [IM_AW+1:0]   w_end;
  logic               w_ovf;
  logic [IM_AW:0]     w_i_nxt;
  logic               w_abort;
  // End address is widened by two bits so a full-memory copy does not wrap
  assign w_end     = {2'b00, im_base} + {1'b0, length};
  assign w_ovf     = w_end > {2'b01, {IM_AW{1'b0}}};
  assign w_i_nxt   = r_i + 1'b1;
  assign w_abort   = abort && (r_state == S_READ || r_state == S_WAIT || r_state == S_WRITE);
  assign HDaddress = r_hd_addr;
  assign im_we     = r_we;
  assign im_addr   = r_im_addr;
  assign im_data   = r_im_data;
  assign busy      = r_busy;
  assign cpu_hold  = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign aborted   = r_aborted;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_hd_base <= '0;
      r_im_base <= '0;
      r_len     <= '0;
      r_i       <= '0;
      r_cnt     <= '0;
      r_hd_addr <= '0;
      r_we      <= 1'b0;
      r_im_addr <= '0;
      r_im_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_aborted <= 1'b0;
      if (w_abort) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_we      <= 1'b0;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: if (start) begin
            if (w_ovf) r_error <= 1'b1;
            else begin
              r_hd_base <= hd_base;
              r_im_base <= im_base;
              r_len     <= length;
              r_i       <= '0;
              r_busy    <= 1'b1;
              if (length == '0) begin
                r_state <= S_FINISH;
                r_done  <= 1'b1;
              end else begin
                r_state   <= S_READ;
                r_hd_addr <= hd_base;
              end
            end
          end
          S_READ: begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: if (r_cnt == 2'(HD_LAT - 1)) begin
            r_we      <= 1'b1;
            r_im_addr <= r_im_base + IM_AW'(r_i);
            r_im_data <= HDIndata;
            r_state   <= S_WRITE;
          end else r_cnt <= r_cnt + 2'd1;
          S_WRITE: begin
            r_we <= 1'b0;
            r_i  <= w_i_nxt;
            if (w_i_nxt == r_len) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_READ;
              r_hd_addr <= r_hd_base + HD_AW'(w_i_nxt);
            end
          end
          S_FINISH: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hd_program_loader.sv
// tb_hd_program_loader: table-driven copies checked against a write scoreboard, plus abort/reset/latency sequences.
module tb_hd_program_loader;
  logic        clock, reset, start, start3, abort;
  logic [11:0] hd_base;
  logic [9:0]  im_base;
  logic [10:0] length;
  logic [11:0] hd_addr, hd_addr3;
  logic [31:0] hd_data, hd_data3, im_data, im_data3;
  logic        im_we, im_we3, busy, busy3, cpu_hold, cpu_hold3;
  logic [9:0]  im_addr, im_addr3;
  logic        done, done3, error, error3, aborted, aborted3;
  int          errs = 0, checks = 0;

  typedef struct packed { logic [9:0] a; logic [31:0] d; } wr_t;
  wr_t q[$];
  typedef struct { logic [11:0] hd; logic [9:0] im; logic [10:0] len; bit rej; int done_cyc; } vec_t;
  vec_t tv[7];

  assign hd_data  = 32'hA000_0000 | {20'h0, hd_addr};
  assign hd_data3 = 32'hA000_0000 | {20'h0, hd_addr3};

  hd_program_loader dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .hd_base(hd_base), .im_base(im_base), .length(length),
    .HDaddress(hd_addr), .HDIndata(hd_data),
    .im_we(im_we), .im_addr(im_addr), .im_data(im_data),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error), .aborted(aborted));

  hd_program_loader #(.HD_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .abort(abort),
    .hd_base(hd_base), .im_base(im_base), .length(length),
    .HDaddress(hd_addr3), .HDIndata(hd_data3),
    .im_we(im_we3), .im_addr(im_addr3), .im_data(im_data3),
    .busy(busy3), .cpu_hold(cpu_hold3), .done(done3), .error(error3), .aborted(aborted3));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic expect_writes(input logic [11:0] hd, input logic [9:0] im, input int n);
    for (int k = 0; k < n; k++) begin
      logic [11:0] h;
      h = 12'(hd + k);
      q.push_back('{a: 10'(im + k), d: 32'hA000_0000 | {20'h0, h}});
    end
  endtask

  task automatic run(input logic [11:0] hd, input logic [9:0] im, input logic [10:0] len,
                     input int ncyc, input int abort_cyc, input int restart_cyc, input int rst_cyc,
                     output int done_cyc, output bit err, output bit ab, output int hold, output int nw);
    wr_t w;
    done_cyc = 0; err = 0; ab = 0; hold = 0; nw = 0;
    @(negedge clock);
    hd_base = hd; im_base = im; length = len; start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clock);
      start = 1'b0;
      abort = 1'b0;
      if (cpu_hold) hold++;
      if (done && done_cyc == 0) done_cyc = c;
      if (error) err = 1;
      if (aborted) ab = 1;
      if (im_we) begin
        nw++;
        if (q.size() == 0) chk("unexpected_write", {54'h0, im_addr}, 64'hFFFF_FFFF);
        else begin
          w = q.pop_front();
          chk("im_addr", im_addr, w.a);
          chk("im_data", im_data, w.d);
        end
      end
      if (c == abort_cyc) abort = 1'b1;
      if (c == restart_cyc) begin
        start = 1'b1; hd_base = 12'h777; im_base = 10'h155; length = 11'd1;
      end
      if (c == rst_cyc) begin
        #1 reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_hdaddr", hd_addr, 0);
        chk("rst_im_addr", im_addr, 0);
        chk("rst_im_data", im_data, 0);
        chk("rst_im_we", im_we, 0);
        #1 reset = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int dc, hold, nw, first3, n3;
    bit er, ab;
    tv[0] = '{hd: 12'h010, im: 10'h000, len: 11'd4, rej: 0, done_cyc: 13};
    tv[1] = '{hd: 12'hFFE, im: 10'h100, len: 11'd3, rej: 0, done_cyc: 10};
    tv[2] = '{hd: 12'h000, im: 10'h3FE, len: 11'd3, rej: 1, done_cyc: 0};
    tv[3] = '{hd: 12'h020, im: 10'h3FE, len: 11'd2, rej: 0, done_cyc: 7};
    tv[4] = '{hd: 12'h123, im: 10'h040, len: 11'd0, rej: 0, done_cyc: 1};
    tv[5] = '{hd: 12'h300, im: 10'h3FF, len: 11'd1, rej: 0, done_cyc: 4};
    tv[6] = '{hd: 12'h300, im: 10'h3FF, len: 11'd2, rej: 1, done_cyc: 0};
    reset = 1'b0; start = 1'b0; start3 = 1'b0; abort = 1'b0;
    hd_base = '0; im_base = '0; length = '0;
    repeat (2) @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_hdaddr", hd_addr, 0);
    chk("reset_pulses", {done, error, aborted, im_we}, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_outputs", {busy, cpu_hold, done, error, aborted, im_we, im_addr, im_data}, 0);

    for (int v = 0; v < 7; v++) begin
      expect_writes(tv[v].hd, tv[v].im, tv[v].rej ? 0 : int'(tv[v].len));
      run(tv[v].hd, tv[v].im, tv[v].len, 20, -1, -1, -1, dc, er, ab, hold, nw);
      chk($sformatf("v%0d_error", v), er, tv[v].rej);
      chk($sformatf("v%0d_done_cycle", v), dc, tv[v].done_cyc);
      chk($sformatf("v%0d_hold_cycles", v), hold, tv[v].done_cyc);
      chk($sformatf("v%0d_writes", v), nw, tv[v].rej ? 0 : int'(tv[v].len));
      chk($sformatf("v%0d_q_empty", v), q.size(), 0);
      q.delete();
    end

    expect_writes(12'h030, 10'h010, 4);
    run(12'h030, 10'h010, 11'd4, 20, -1, 5, -1, dc, er, ab, hold, nw);
    chk("busy_start_error", er, 0);
    chk("busy_start_done", dc, 13);
    chk("busy_start_writes", nw, 4);
    chk("busy_start_q_empty", q.size(), 0);
    q.delete();

    expect_writes(12'h040, 10'h050, 2);
    run(12'h040, 10'h050, 11'd8, 30, 6, -1, -1, dc, er, ab, hold, nw);
    chk("abort_pulse", ab, 1);
    chk("abort_no_done", dc, 0);
    chk("abort_writes", nw, 2);
    chk("abort_hold_cycles", hold, 6);
    chk("abort_q_empty", q.size(), 0);
    q.delete();

    expect_writes(12'h060, 10'h000, 2);
    run(12'h060, 10'h000, 11'd2, 15, -1, -1, -1, dc, er, ab, hold, nw);
    chk("after_abort_done", dc, 7);
    chk("after_abort_writes", nw, 2);
    q.delete();

    expect_writes(12'h010, 10'h001, 2);
    run(12'h010, 10'h001, 11'd4, 20, -1, -1, 8, dc, er, ab, hold, nw);
    chk("reset_mid_writes", nw, 2);
    chk("reset_mid_no_pulse", {dc != 0, ab}, 0);
    chk("reset_mid_q_empty", q.size(), 0);
    q.delete();
    @(negedge clock);
    chk("post_reset_idle", {busy, done, aborted}, 0);

    @(negedge clock);
    hd_base = 12'h100; im_base = 10'h200; length = 11'd3; start3 = 1'b1;
    dc = 0; first3 = 0; n3 = 0; hold = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clock);
      start3 = 1'b0;
      if (cpu_hold3) hold++;
      if (done3 && dc == 0) dc = c;
      if (im_we3) begin
        if (first3 == 0) first3 = c;
        chk("lat3_im_addr", im_addr3, 10'(10'h200 + n3));
        chk("lat3_im_data", im_data3, 32'hA000_0100 + n3);
        n3++;
      end
    end
    chk("lat3_first_write", first3, 5);
    chk("lat3_done", dc, 16);
    chk("lat3_writes", n3, 3);
    chk("lat3_hold", hold, 16);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
